// File: rtl/pipe_seg_hs.sv
// Pipeline segment register with valid/ready handshake between front-end stages.
// Optional two-entry skid keeps in_ready registered so ready never ripples across stages.
module pipe_seg_hs #(
   parameter int unsigned DATA_W        = 32,
   parameter bit          SKID_EN       = 1'b1,
   parameter bit          ZERO_ON_FLUSH = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [1:0]        o_occ
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   if (SKID_EN) begin : g_skid
      state_e            r_state;
      logic              r_in_ready;
      logic              r_out_valid;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic              w_accept;
      logic              w_pop;

      assign w_accept = i_in_valid & r_in_ready;
      assign w_pop    = r_out_valid & i_out_ready;

      // in_ready and out_valid are kept as registers alongside the state so no
      // output depends combinationally on any input.
      always_ff @(posedge i_clk) begin
         if (!i_resetn) begin
            r_state     <= StEmpty;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
         end else if (i_flush) begin
            r_state     <= StEmpty;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            if (ZERO_ON_FLUSH) begin
               r_main <= '0;
               r_skid <= '0;
            end
         end else begin
            unique case (r_state)
               StEmpty: begin
                  if (w_accept) begin
                     r_main      <= i_in_data;
                     r_state     <= StOne;
                     r_out_valid <= 1'b1;
                  end
               end
               StOne: begin
                  if (w_accept && !w_pop) begin
                     r_skid     <= i_in_data;
                     r_state    <= StTwo;
                     r_in_ready <= 1'b0;
                  end else if (w_accept) begin
                     r_main <= i_in_data;
                  end else if (w_pop) begin
                     r_state     <= StEmpty;
                     r_out_valid <= 1'b0;
                  end
               end
               StTwo: begin
                  if (w_pop) begin
                     r_main     <= r_skid;
                     r_state    <= StOne;
                     r_in_ready <= 1'b1;
                  end
               end
               default: begin
                  r_state     <= StEmpty;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            endcase
         end
      end

      assign o_in_ready  = r_in_ready;
      assign o_out_valid = r_out_valid;
      assign o_out_data  = r_main;
      assign o_occ       = r_state;
   end else begin : g_single
      logic              r_valid;
      logic [DATA_W-1:0] r_main;
      logic              w_in_ready;
      logic              w_accept;
      logic              w_pop;

      // Combinational ready: a full register can refill in the cycle it drains.
      assign w_in_ready = ~r_valid | i_out_ready;
      assign w_accept   = i_in_valid & w_in_ready;
      assign w_pop      = r_valid & i_out_ready;

      always_ff @(posedge i_clk) begin
         if (!i_resetn) begin
            r_valid <= 1'b0;
            r_main  <= '0;
         end else if (i_flush) begin
            r_valid <= 1'b0;
            if (ZERO_ON_FLUSH) begin
               r_main <= '0;
            end
         end else if (w_accept) begin
            r_main  <= i_in_data;
            r_valid <= 1'b1;
         end else if (w_pop) begin
            r_valid <= 1'b0;
         end
      end

      assign o_in_ready  = w_in_ready;
      assign o_out_valid = r_valid;
      assign o_out_data  = r_main;
      assign o_occ       = {1'b0, r_valid};
   end

endmodule

// File: doc/pipe_seg_hs.md
Name: pipe_seg_hs

Overview:
Parametrised pipeline segment register that replaces the fixed stall/refresh stage registers between front-end stages (pd->id, id->ex, ...). It carries an opaque DATA_W-bit payload bundle with a valid/ready handshake instead of a global stall. An optional skid entry makes in_ready purely registered, which breaks the combinational ready path across stages. Flush (refresh) discards all held entries in one cycle.

Parameters:
DATA_W, 32, payload width in bits (>=1); the caller concatenates all stage fields into one bus.
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
ZERO_ON_FLUSH, 1, 1 = payload registers cleared to 0 on flush/reset; 0 = payload held and only valid cleared.

Ports:
clk  in  1  clock; all state updates on posedge.
resetn  in  1  synchronous active-low reset.
flush  in  1  refresh; discards every entry this cycle.
in_valid  in  1  upstream has a payload.
in_ready  out  1  this stage accepts a payload this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream consumes out_data this cycle.
out_data  out  DATA_W  payload presented downstream, always from the main register.
occ  out  2  entries held: 0, 1 or 2 (2 only when SKID_EN=1).

Behaviour:
- Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready. Payload moves only on a handshake. out_data and out_valid are register outputs with no combinational path from in_*.
- Reset (resetn=0 at posedge): state EMPTY, out_valid=0, occ=0, main and skid payload = 0. Reset has priority over flush and over any handshake. A reset mid-transfer drops both entries.
- Flush (resetn=1, flush=1): next state EMPTY, out_valid=0, occ=0. A simultaneous accept is dropped and a simultaneous pop is ignored. Payload is zeroed when ZERO_ON_FLUSH=1, otherwise held.
- SKID_EN=1 state machine (occ mirrors the state):
  - States: EMPTY(0), ONE(1, main full), TWO(2, main+skid full).
  - in_ready = (state != TWO), registered.
  - out_valid = (state != EMPTY).
  - EMPTY: accept -> main<=in_data, ONE.
  - ONE: accept & !pop -> skid<=in_data, TWO. accept & pop -> main<=in_data, ONE. !accept & pop -> EMPTY. Otherwise hold.
  - TWO: pop -> main<=skid, ONE (no accept possible). Otherwise hold.
- SKID_EN=0:
  - Single register; in_ready = !out_valid | out_ready (combinational).
  - accept -> main<=in_data, out_valid<=1.
  - pop & !accept -> out_valid<=0.
  - occ = {1'b0, out_valid}.
- Latency: 1 cycle from accept to out_valid when the stage was empty or popping. Throughput is 1 per cycle with out_ready held high in both modes.
- Ordering: strict FIFO. No payload is duplicated or lost except by flush or reset.
- Payload in a non-valid register is don't-care for consumers. Verification checks out_data only while out_valid=1, except for zero checks after reset or flush with ZERO_ON_FLUSH=1.
- in_data is sampled only on accept. in_valid may drop without a handshake; no protocol assertion is made on the upstream side.

Test Plan:
- Reset: resetn=0 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, occ=0, out_data=0, in_ready=1 after release.
- Streaming (SKID_EN=1 and SKID_EN=0): push 1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 on cycles 1-4 after the first accept, occ stays 1, in_ready stays 1.
- Backpressure (SKID_EN=1): out_ready=0, push A then B -> occ=2, in_ready=0 on the next cycle, C is held upstream. Then set out_ready=1 -> out_data A, B, C in order, no loss.
- Flush with ZERO_ON_FLUSH=1: occ=2 holding A,B, then flush=1 together with in_valid=1 (C) and out_ready=1 -> next cycle occ=0, out_valid=0, out_data=0. C is never emitted.
- Flush with ZERO_ON_FLUSH=0: main=32'h1234 and flush -> out_valid=0, out_data remains 32'h1234.
- Random: random in_valid, out_ready, flush at 10% for 10k cycles against a scoreboard queue -> order preserved, occ matches the model, in_ready never 1 when occ=2.
